// File: rtl/nw_arb_pkg.sv
// rtl/nw_arb_pkg.sv - shared types and constants for the strategy arbiter
package nw_arb_pkg;

   typedef enum logic [1:0] {
      NW_ARB_FIXED,
      NW_ARB_RR,
      NW_ARB_WRR,
      NW_ARB_RSVD
   } nw_arb_strategy_e;

   typedef enum logic {
      NW_ARB_IDLE,
      NW_ARB_BUSY
   } nw_arb_state_e;

   localparam int NW_ARB_STAT_W = 16;

endpackage

// File: rtl/nw_rr_pick.sv
// rtl/nw_rr_pick.sv - rotate-priority picker: first set mask bit at or after start, wrapping
module nw_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int               c;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      c     = 0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         c = int'(start) + k;
         if (c >= N) c = c - N;
         cand = IDX_W'(c);
         if (!found && mask[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/nw_strategy_arbiter.sv
// rtl/nw_strategy_arbiter.sv - packet arbiter with runtime-selectable strategy
// Optional per-requester grant counters: NW_STRATEGY_ARB_STATS_EN
module nw_strategy_arbiter
   import nw_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int WEIGHT_W = 4,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  cfg_strategy,
   input  logic [NUM_REQ*WEIGHT_W-1:0] cfg_weight,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        res_valid,
   output logic                        res_last,
   input  logic                        res_ready,
   output logic                        gnt_active,
`ifdef NW_STRATEGY_ARB_STATS_EN
   input  logic                        stat_clr,
   output logic [NUM_REQ*NW_ARB_STAT_W-1:0] stat_grants,
`endif
   output logic [ID_W-1:0]             gnt_id
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

   nw_arb_state_e    state, state_nxt;
   nw_arb_strategy_e strat;

   logic [ID_W-1:0]     last_winner, rr_start, pick_start, pick_idx;
   logic [NUM_REQ-1:0]  pick_mask, credit_nz, wrr_elig;
   logic                pick_found, do_grant, wrr_reload, pkt_done;
   logic [WEIGHT_W-1:0] credit      [NUM_REQ];
   logic [WEIGHT_W-1:0] weight_eff  [NUM_REQ];
   logic [WEIGHT_W-1:0] credit_base [NUM_REQ];

   assign strat    = nw_arb_strategy_e'(cfg_strategy);
   assign rr_start = (last_winner == LAST_IDX) ? '0 : last_winner + ID_W'(1);

   // A weight of 0 still earns one packet per round.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         weight_eff[i] = (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                         WEIGHT_W'(1) : cfg_weight[i*WEIGHT_W +: WEIGHT_W];
         credit_nz[i]  = (credit[i] != '0);
      end
      wrr_elig   = req_valid & credit_nz;
      wrr_reload = (strat == NW_ARB_WRR) && (wrr_elig == '0);
      for (int i = 0; i < NUM_REQ; i++)
         credit_base[i] = wrr_reload ? weight_eff[i] : credit[i];
   end

   // Fixed priority reuses the rotating picker with the search pinned at 0.
   always_comb begin
      case (strat)
         NW_ARB_RR: begin
            pick_mask  = req_valid;
            pick_start = rr_start;
         end
         NW_ARB_WRR: begin
            pick_mask  = wrr_reload ? req_valid : wrr_elig;
            pick_start = rr_start;
         end
         default: begin
            pick_mask  = req_valid;
            pick_start = '0;
         end
      endcase
   end

   nw_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .mask  (pick_mask),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign do_grant = (state == NW_ARB_IDLE) && pick_found;
   assign pkt_done = (state == NW_ARB_BUSY) && req_valid[gnt_id] &&
                     res_ready && req_last[gnt_id];

   always_ff @(posedge clk) begin
      if (rst) state <= NW_ARB_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         NW_ARB_IDLE: if (do_grant) state_nxt = NW_ARB_BUSY;
         NW_ARB_BUSY: if (pkt_done) state_nxt = NW_ARB_IDLE;
         default:     state_nxt = NW_ARB_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      res_valid  = 1'b0;
      res_last   = 1'b0;
      gnt_active = 1'b0;
      if (state == NW_ARB_BUSY) begin
         gnt_active        = 1'b1;
         res_valid         = req_valid[gnt_id];
         res_last          = req_last[gnt_id];
         req_ready[gnt_id] = res_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_id      <= '0;
         last_winner <= LAST_IDX;
         for (int i = 0; i < NUM_REQ; i++) credit[i] <= weight_eff[i];
      end else if (do_grant) begin
         gnt_id      <= pick_idx;
         last_winner <= pick_idx;
         if (strat == NW_ARB_WRR) begin
            for (int i = 0; i < NUM_REQ; i++)
               credit[i] <= credit_base[i] -
                            ((ID_W'(i) == pick_idx) ? WEIGHT_W'(1) : WEIGHT_W'(0));
         end
      end
   end

`ifdef NW_STRATEGY_ARB_STATS_EN
   logic [NW_ARB_STAT_W-1:0] stat_cnt [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst || stat_clr)
            stat_cnt[i] <= '0;
         else if (do_grant && (ID_W'(i) == pick_idx) && (stat_cnt[i] != '1))
            stat_cnt[i] <= stat_cnt[i] + NW_ARB_STAT_W'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         stat_grants[i*NW_ARB_STAT_W +: NW_ARB_STAT_W] = stat_cnt[i];
   end
`endif

endmodule

// File: tb/tb_nw_strategy_arbiter.sv
// tb/tb_nw_strategy_arbiter.sv - directed self-checking bench for nw_strategy_arbiter
module tb_nw_strategy_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    cfg_strategy;
   logic [N*WW-1:0] cfg_weight;
   logic [N-1:0]  req_valid, req_last, req_ready;
   logic          res_valid, res_last, res_ready, gnt_active;
   logic [1:0]    gnt_id;
`ifdef NW_STRATEGY_ARB_STATS_EN
   logic          stat_clr;
   logic [N*16-1:0] stat_grants;
`endif

   int checks   = 0;
   int failures = 0;

   int wrr_seq [14] = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3, 0, 1, 0, 0};

   always #5 clk = ~clk;

   nw_strategy_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_strategy (cfg_strategy),
      .cfg_weight   (cfg_weight),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .res_valid    (res_valid),
      .res_last     (res_last),
      .res_ready    (res_ready),
      .gnt_active   (gnt_active),
`ifdef NW_STRATEGY_ARB_STATS_EN
      .stat_clr     (stat_clr),
      .stat_grants  (stat_grants),
`endif
      .gnt_id       (gnt_id)
   );

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // One-beat packet from IDLE: granted after one edge, back to IDLE after the next.
   task automatic grant1(input string tag, input int exp);
      step();
      chk({tag, "_act"}, gnt_active, 1);
      chk({tag, "_id"}, gnt_id, exp);
      chk({tag, "_rdy"}, req_ready, 1 << exp);
      step();
      chk({tag, "_idle"}, gnt_active, 0);
   endtask

   initial begin
      cfg_strategy = 2'd0;
      cfg_weight   = 16'h1023;
      res_ready    = 1'b0;
`ifdef NW_STRATEGY_ARB_STATS_EN
      stat_clr     = 1'b0;
`endif
      do_reset();
      chk("rst_act", gnt_active, 0);
      chk("rst_id", gnt_id, 0);
      chk("rst_vld", res_valid, 0);
      chk("rst_last", res_last, 0);
      chk("rst_rdy", req_ready, 0);

      // Fixed priority: r1 starves r3
      cfg_strategy = 2'd0;
      req_valid = 4'b1010; req_last = 4'b1111; res_ready = 1'b1;
      for (int i = 0; i < 3; i++) grant1($sformatf("fix%0d", i), 1);

      // Round robin from reset
      do_reset();
      cfg_strategy = 2'd1;
      req_valid = 4'b1111; req_last = 4'b1111; res_ready = 1'b1;
      for (int i = 0; i < 5; i++) grant1($sformatf("rr%0d", i), i % 4);

      // Weighted RR: weights {1,0,2,3}, two full rounds
      cfg_weight = 16'h1023;
      do_reset();
      cfg_strategy = 2'd2;
      req_valid = 4'b1111; req_last = 4'b1111; res_ready = 1'b1;
      for (int i = 0; i < 14; i++) grant1($sformatf("wrr%0d", i), wrr_seq[i]);

      // Packet lock: r2 4-beat packet, ready 1,0,1,1,1, r0 waiting
      do_reset();
      cfg_strategy = 2'd1;
      req_valid = 4'b0100; req_last = 4'b0000; res_ready = 1'b1;
      step();
      chk("lock_id0", gnt_id, 2);
      chk("lock_vld0", res_valid, 1);
      chk("lock_rdy0", req_ready, 4'b0100);
      req_valid = 4'b0101; req_last = 4'b0001;
      step();
      res_ready = 1'b0; #1;
      chk("lock_stall_rdy", req_ready, 0);
      chk("lock_stall_vld", res_valid, 1);
      chk("lock_stall_id", gnt_id, 2);
      step();
      res_ready = 1'b1; #1;
      chk("lock_rdy2", req_ready, 4'b0100);
      step();
      chk("lock_id3", gnt_id, 2);
      step();
      req_last = 4'b0101; #1;
      chk("lock_last", res_last, 1);
      chk("lock_id4", gnt_id, 2);
      step();
      chk("lock_idle", gnt_active, 0);
      req_valid = 4'b0001;
      step();
      chk("lock_next_act", gnt_active, 1);
      chk("lock_next_id", gnt_id, 0);

      // Strategy change RR->fixed during r1's packet
      do_reset();
      cfg_strategy = 2'd1;
      req_valid = 4'b0010; req_last = 4'b0000; res_ready = 1'b1;
      step();
      chk("chg_id0", gnt_id, 1);
      cfg_strategy = 2'd0;
      req_valid = 4'b0111; req_last = 4'b0010; #1;
      chk("chg_id1", gnt_id, 1);
      chk("chg_rdy", req_ready, 4'b0010);
      step();
      chk("chg_idle", gnt_active, 0);
      step();
      chk("chg_next_id", gnt_id, 0);
      chk("chg_next_act", gnt_active, 1);

      // Reset on beat 2 of r2's packet
      do_reset();
      cfg_strategy = 2'd1;
      req_valid = 4'b0100; req_last = 4'b0000; res_ready = 1'b1;
      step();
      chk("mrst_id0", gnt_id, 2);
      step();
      rst = 1'b1;
      step();
      chk("mrst_act", gnt_active, 0);
      chk("mrst_vld", res_valid, 0);
      chk("mrst_rdy", req_ready, 0);
      chk("mrst_id", gnt_id, 0);
      rst = 1'b0;
      req_valid = 4'b1111; req_last = 4'b1111;
      grant1("mrst_first", 0);

      // Reserved strategy code behaves as fixed priority
      do_reset();
      cfg_strategy = 2'd3;
      req_valid = 4'b0100; req_last = 4'b1111; res_ready = 1'b1;
      grant1("rsvd0", 2);
      req_valid = 4'b1100;
      grant1("rsvd1", 2);

`ifdef NW_STRATEGY_ARB_STATS_EN
      do_reset();
      chk("stat_rst", stat_grants[15:0], 0);
      cfg_strategy = 2'd0;
      req_valid = 4'b0001; req_last = 4'b1111; res_ready = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         step();
         step();
      end
      chk("stat_sat", stat_grants[15:0], 65535);
      chk("stat_r1", stat_grants[31:16], 0);
      stat_clr = 1'b1;
      step();
      chk("stat_clr_grant_act", gnt_active, 1);
      chk("stat_clr_grant", stat_grants[15:0], 0);
      stat_clr = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
